// File: rtl/matmul_pkg.sv
// Shared constants, stream state encoding and element-slice helper for the 4x4 matrix multiplier family.
// MATRIX_STREAM_CHECKSUM_EN adds the CSUM state to the stream state encoding.
package matmul_pkg;
    localparam int MM_N     = 4;
    localparam int MM_W     = 16;
    localparam int MM_IDX_W = $clog2(MM_N);

`ifdef MATRIX_STREAM_CHECKSUM_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_CSUM   = 2'd2
    } stream_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1
    } stream_state_e;
`endif

    // Bit offset of element (i,j) inside a flattened row-major n x n matrix of w-bit elements.
    function automatic int elem_off(input int i, input int j, input int n, input int w);
        return (i * n + j) * w;
    endfunction
endpackage

// File: rtl/matrix_result_streamer_if.sv
// Valid/ready element stream carrying one matrix element per beat with its row/column tag.
interface matrix_result_streamer_if #(
    parameter int W     = 16,
    parameter int IDX_W = 2
);
    logic [W-1:0]     m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;
    logic [IDX_W-1:0] m_row;
    logic [IDX_W-1:0] m_col;

    modport master (output m_data, output m_valid, output m_last, output m_row, output m_col,
                    input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, input m_row, input m_col,
                    output m_ready);
endinterface

// File: rtl/matrix_result_streamer.sv
// Captures the multiplier's C matrix on mm_done and streams it row-major over a valid/ready handshake.
// MATRIX_STREAM_CHECKSUM_EN appends an XOR checksum beat after the last element.
module matrix_result_streamer
    import matmul_pkg::*;
#(
    parameter int N = MM_N,
    parameter int W = MM_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mm_done,
    input  logic [N*N*W-1:0]         mm_c,
    matrix_result_streamer_if.master strm,
    output logic                     busy,
    output logic                     err_drop
);
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = 2 * IDX_W;
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(N * N - 1);

    stream_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N*N*W-1:0] buf_q, buf_d;
    logic             err_drop_q, err_drop_d;
    logic             fire, final_hs, capture;
    logic [IDX_W-1:0] row, col;

`ifdef MATRIX_STREAM_CHECKSUM_EN
    logic [W-1:0] csum_q, csum_d;

    function automatic logic [W-1:0] xor_fold(input logic [N*N*W-1:0] c);
        logic [W-1:0] acc;
        acc = '0;
        for (int k = 0; k < N * N; k++) acc = acc ^ c[k*W +: W];
        return acc;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            err_drop_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            err_drop_q <= err_drop_d;
        end
    end

    // Element buffer carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
`ifdef MATRIX_STREAM_CHECKSUM_EN
        csum_q <= csum_d;
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (mm_done) state_d = ST_STREAM;
`ifdef MATRIX_STREAM_CHECKSUM_EN
            ST_STREAM: if (fire && cnt_q == LAST_K) state_d = ST_CSUM;
            ST_CSUM:   if (fire) state_d = mm_done ? ST_STREAM : ST_IDLE;
`else
            ST_STREAM: if (fire && cnt_q == LAST_K) state_d = mm_done ? ST_STREAM : ST_IDLE;
`endif
            default:   state_d = ST_IDLE;
        endcase
    end

    // A new matrix is accepted only when idle or on the handshake of the final beat.
    always_comb begin
        fire       = strm.m_valid && strm.m_ready;
`ifdef MATRIX_STREAM_CHECKSUM_EN
        final_hs   = fire && (state_q == ST_CSUM);
`else
        final_hs   = fire && (state_q == ST_STREAM) && (cnt_q == LAST_K);
`endif
        capture    = mm_done && ((state_q == ST_IDLE) || final_hs);
        err_drop_d = err_drop_q | (mm_done && !capture);
        buf_d      = capture ? mm_c : buf_q;
        cnt_d      = cnt_q;
        if (capture)
            cnt_d = '0;
        else if (fire && (state_q == ST_STREAM) && (cnt_q != LAST_K))
            cnt_d = cnt_q + CNT_W'(1);
`ifdef MATRIX_STREAM_CHECKSUM_EN
        csum_d     = capture ? xor_fold(mm_c) : csum_q;
`endif
    end

    always_comb begin
        row          = cnt_q[CNT_W-1:IDX_W];
        col          = cnt_q[IDX_W-1:0];
        strm.m_valid = (state_q != ST_IDLE);
        strm.m_row   = row;
        strm.m_col   = col;
        strm.m_data  = '0;
        strm.m_last  = 1'b0;
        if (state_q == ST_STREAM)
            strm.m_data = buf_q[elem_off(int'(row), int'(col), N, W) +: W];
`ifdef MATRIX_STREAM_CHECKSUM_EN
        if (state_q == ST_CSUM) begin
            strm.m_data = csum_q;
            strm.m_last = 1'b1;
        end
`else
        strm.m_last = (state_q == ST_STREAM) && (cnt_q == LAST_K);
`endif
        busy         = strm.m_valid;
        err_drop     = err_drop_q;
    end
endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed scoreboard bench for matrix_result_streamer; honours MATRIX_STREAM_CHECKSUM_EN.
module tb_matrix_result_streamer;
    import matmul_pkg::*;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  r;
        logic [1:0]  c;
        logic        l;
    } beat_t;

`ifdef MATRIX_STREAM_CHECKSUM_EN
    localparam int BEATS = 17;
`else
    localparam int BEATS = 16;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         mm_done;
    logic [255:0] mm_c;
    logic         busy;
    logic         err_drop;

    matrix_result_streamer_if #(.W(16), .IDX_W(2)) strm ();

    matrix_result_streamer #(.N(4), .W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .mm_done  (mm_done),
        .mm_c     (mm_c),
        .strm     (strm),
        .busy     (busy),
        .err_drop (err_drop)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    beat_t q[$];

    logic        stalled_prev = 1'b0;
    logic [15:0] sv_data;
    logic [1:0]  sv_row, sv_col;
    logic        sv_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int base);
        for (int k = 0; k < 16; k++) mm_c[k*16 +: 16] = 16'(base + k);
    endtask

    task automatic push_matrix(input int base);
        beat_t       b;
        logic [15:0] x;
        x = '0;
        for (int k = 0; k < 16; k++) begin
            b.d = 16'(base + k);
            b.r = 2'(k / 4);
            b.c = 2'(k % 4);
            b.l = (k == 15) && (BEATS == 16);
            x   = x ^ b.d;
            q.push_back(b);
        end
`ifdef MATRIX_STREAM_CHECKSUM_EN
        b.d = x;
        b.r = 2'd3;
        b.c = 2'd3;
        b.l = 1'b1;
        q.push_back(b);
`endif
    endtask

    // One clock cycle: inputs applied, outputs checked, then the edge.
    task automatic tick(input logic done, input logic rdy);
        beat_t e;
        mm_done      = done;
        strm.m_ready = rdy;
        if (stalled_prev) begin
            chk("stall_valid", strm.m_valid, 1);
            chk("stall_data",  strm.m_data,  sv_data);
            chk("stall_row",   strm.m_row,   sv_row);
            chk("stall_col",   strm.m_col,   sv_col);
            chk("stall_last",  strm.m_last,  sv_last);
        end
        if (strm.m_valid && rdy) begin
            if (q.size() == 0) begin
                chk("extra_beat", q.size(), 1);
            end else begin
                e = q.pop_front();
                chk("beat_data", strm.m_data, e.d);
                chk("beat_row",  strm.m_row,  e.r);
                chk("beat_col",  strm.m_col,  e.c);
                chk("beat_last", strm.m_last, e.l);
            end
        end
        stalled_prev = strm.m_valid && !rdy;
        sv_data = strm.m_data;
        sv_row  = strm.m_row;
        sv_col  = strm.m_col;
        sv_last = strm.m_last;
        @(posedge clk);
        #1;
        mm_done = 1'b0;
    endtask

    // mode 0: always ready; mode 1: ready pattern 1,0,0,1 repeating.
    task automatic drain(input int mode, output int cycles);
        int  ph;
        logic r;
        cycles = 0;
        ph     = 0;
        while (q.size() > 0 && cycles < 200) begin
            r = (mode == 0) ? 1'b1 : ((ph % 4 == 0) || (ph % 4 == 3));
            tick(1'b0, r);
            ph++;
            cycles++;
        end
        chk("drain_left", q.size(), 0);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        strm.m_ready = 1'b0;
        mm_done      = 1'b0;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        q.delete();
        stalled_prev = 1'b0;
    endtask

    initial begin
        int cyc;
        int guard;
        rst          = 1'b1;
        mm_done      = 1'b0;
        mm_c         = '0;
        strm.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",    strm.m_valid, 0);
        chk("rst_last",     strm.m_last,  0);
        chk("rst_data",     strm.m_data,  0);
        chk("rst_row",      strm.m_row,   0);
        chk("rst_col",      strm.m_col,   0);
        chk("rst_busy",     busy,         0);
        chk("rst_err_drop", err_drop,     0);
        rst = 1'b0;
        tick(1'b0, 1'b1);

        // Straight stream with consumer always ready.
        load(1);
        push_matrix(1);
        tick(1'b1, 1'b1);
        chk("lat1_valid", strm.m_valid, 1);
        chk("lat1_busy",  busy,         1);
        chk("lat1_data",  strm.m_data,  16'd1);
        drain(0, cyc);
        chk("t1_cycles",  cyc,          BEATS);
        chk("t1_valid",   strm.m_valid, 0);
        chk("t1_busy",    busy,         0);

        // Back-pressure 1,0,0,1.
        push_matrix(1);
        tick(1'b1, 1'b1);
        drain(1, cyc);
        tick(1'b0, 1'b1);
        chk("t2_valid", strm.m_valid, 0);
        chk("t2_err",   err_drop,     0);

        // Dropped mm_done mid-stream must not disturb the buffer.
        push_matrix(1);
        tick(1'b1, 1'b1);
        repeat (5) tick(1'b0, 1'b1);
        load(100);
        tick(1'b1, 1'b1);
        chk("drop_err_next", err_drop, 1);
        drain(0, cyc);
        tick(1'b0, 1'b0);
        chk("drop_err_sticky", err_drop, 1);
        chk("drop_idle",       strm.m_valid, 0);
        do_reset();
        chk("drop_err_rst",    err_drop, 0);

        // Back-to-back capture on the final handshake.
        load(1);
        push_matrix(1);
        tick(1'b1, 1'b1);
        guard = 0;
        while (q.size() > 1 && guard < 100) begin
            tick(1'b0, 1'b1);
            guard++;
        end
        chk("b2b_at_final", q.size(), 1);
        load(17);
        push_matrix(17);
        tick(1'b1, 1'b1);
        chk("b2b_valid", strm.m_valid, 1);
        chk("b2b_data",  strm.m_data,  16'd17);
        chk("b2b_row",   strm.m_row,   0);
        chk("b2b_col",   strm.m_col,   0);
        drain(0, cyc);
        chk("b2b_cycles", cyc,          BEATS);
        chk("b2b_idle",   strm.m_valid, 0);
        chk("b2b_err",    err_drop,     0);

        // Reset mid-stream abandons the matrix.
        load(1);
        push_matrix(1);
        tick(1'b1, 1'b1);
        repeat (7) tick(1'b0, 1'b1);
        chk("pre_rst_data", strm.m_data, 16'd8);
        do_reset();
        chk("mid_rst_valid", strm.m_valid, 0);
        chk("mid_rst_busy",  busy,         0);
        chk("mid_rst_err",   err_drop,     0);
        chk("mid_rst_data",  strm.m_data,  0);
        tick(1'b0, 1'b1);
        chk("mid_rst_quiet", strm.m_valid, 0);
        load(33);
        push_matrix(33);
        tick(1'b1, 1'b1);
        chk("fresh_row", strm.m_row, 0);
        chk("fresh_col", strm.m_col, 0);
        drain(1, cyc);
        tick(1'b0, 1'b1);
        chk("fresh_idle", strm.m_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
